// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, divider
// FSM states and default widths.
package mdu_pkg;

  localparam int XLEN_DEFAULT       = 32;
  localparam int REG_ADDR_W_DEFAULT = 5;

  // bit0 = unsigned, bit1 = remainder
  localparam logic [2:0] DIV_OP_DIV  = 3'b100;
  localparam logic [2:0] DIV_OP_DIVU = 3'b101;
  localparam logic [2:0] DIV_OP_REM  = 3'b110;
  localparam logic [2:0] DIV_OP_REMU = 3'b111;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } div_state_e;

endpackage

// File: rtl/div_iter_step.sv
// One restoring shift-subtract division step on unsigned magnitudes.
module div_iter_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] quo_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic [XLEN-1:0] quo_out
);

  logic [XLEN:0]   shifted;
  logic [XLEN+1:0] diff;
  logic            ge;

  // Shift the next dividend bit into the partial remainder and trial-subtract;
  // the extra top bit of diff is the borrow.
  always_comb begin
    shifted = {rem_in, quo_in[XLEN-1]};
    diff    = {1'b0, shifted} - {2'b00, divisor};
    ge      = ~diff[XLEN+1];
    rem_out = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    quo_out = {quo_in[XLEN-2:0], ge};
  end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle RV32M divide/remainder sequencer. Stalls the pipeline while a
// restoring divide runs and returns one result plus destination register.
//
//  state | meaning
//  IDLE  | waiting for start; divide-by-zero and signed overflow resolve here
//  LOAD  | seed quotient with |dividend|, clear partial remainder and count
//  RUN   | one restoring step per cycle, XLEN cycles
//  FIX   | apply result signs, select quotient or remainder into result
//  DONE  | one-cycle done/wb_en pulse, then back to IDLE
module div_sequencer
  import mdu_pkg::*;
#(
  parameter int XLEN       = XLEN_DEFAULT,
  parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2:0]            div_op,
  input  logic [XLEN-1:0]       rs1_val,
  input  logic [XLEN-1:0]       rs2_val,
  input  logic [REG_ADDR_W-1:0] rd_in,
  input  logic                  flush,
  output logic                  busy,
  output logic                  stall_pipe,
  output logic                  done,
  output logic                  wb_en,
  output logic [XLEN-1:0]       result,
  output logic [REG_ADDR_W-1:0] rd_out
);

  localparam int              CNT_W     = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e state, state_nxt;

  logic [1:0]       op_r;
  logic             neg_a, neg_b;
  logic [XLEN-1:0]  mag_a, mag_b;
  logic [XLEN-1:0]  rem_r, quo_r;
  logic [CNT_W-1:0] count;

  logic             in_neg_a, in_neg_b;
  logic             div_zero, div_ovf, launch;
  logic [XLEN-1:0]  step_rem, step_quo;
  logic [XLEN-1:0]  quo_fix, rem_fix;

  // The decoder only launches divide ops, so the class bit carries no information here.
  logic unused_op_bit;
  assign unused_op_bit = div_op[2];

  // Launch-time operand classification.
  always_comb begin
    in_neg_a = rs1_val[XLEN-1] & ~div_op[0];
    in_neg_b = rs2_val[XLEN-1] & ~div_op[0];
    div_zero = (rs2_val == '0);
    div_ovf  = ~div_op[0] & (rs1_val == MIN_NEG) & (rs2_val == '1);
    launch   = (state == IDLE) & start & ~flush;
    quo_fix  = (neg_a ^ neg_b) ? -quo_r : quo_r;
    rem_fix  = neg_a ? -rem_r : rem_r;
  end

  div_iter_step #(.XLEN(XLEN)) u_step (
    .rem_in  (rem_r),
    .quo_in  (quo_r),
    .divisor (mag_b),
    .rem_out (step_rem),
    .quo_out (step_quo)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and status outputs; flush overrides everything.
  always_comb begin
    state_nxt  = state;
    busy       = (state != IDLE);
    stall_pipe = 1'b0;
    done       = 1'b0;
    wb_en      = 1'b0;
    case (state)
      IDLE: begin
        stall_pipe = start;
        if (launch) state_nxt = (div_zero | div_ovf) ? DONE : LOAD;
      end
      LOAD: begin
        stall_pipe = 1'b1;
        state_nxt  = RUN;
      end
      RUN: begin
        stall_pipe = 1'b1;
        if (count == LAST_STEP) state_nxt = FIX;
      end
      FIX: begin
        stall_pipe = 1'b1;
        state_nxt  = DONE;
      end
      DONE: begin
        done      = ~flush;
        wb_en     = ~flush & (rd_out != '0);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // Datapath: operand capture, iteration registers and result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r   <= '0;
      rd_out <= '0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      mag_a  <= '0;
      mag_b  <= '0;
      rem_r  <= '0;
      quo_r  <= '0;
      count  <= '0;
      result <= '0;
    end else begin
      if (launch) begin
        op_r   <= div_op[1:0];
        rd_out <= rd_in;
        neg_a  <= in_neg_a;
        neg_b  <= in_neg_b;
        mag_a  <= in_neg_a ? -rs1_val : rs1_val;
        mag_b  <= in_neg_b ? -rs2_val : rs2_val;
        if (div_zero)     result <= div_op[1] ? rs1_val : '1;
        else if (div_ovf) result <= div_op[1] ? '0 : MIN_NEG;
      end
      if (state == LOAD) begin
        quo_r <= mag_a;
        rem_r <= '0;
        count <= '0;
      end
      if (state == RUN) begin
        rem_r <= step_rem;
        quo_r <= step_quo;
        count <= count + 1'b1;
      end
      if (state == FIX && !flush) result <= op_r[1] ? rem_fix : quo_fix;
    end
  end

endmodule
